// File: rtl/f_spsram_arb_ctrl_if.sv
// Bus bundle for f_spsram_arb_ctrl: both request ports,
// the zero-fill control and the single-port SRAM pins.
interface f_spsram_arb_ctrl_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 128,
  parameter int STRB_WIDTH = 16
);
  logic                  p0_req;
  logic [ADDR_WIDTH-1:0] p0_addr;
  logic                  p0_gnt;
  logic                  p0_rvalid;
  logic [DATA_WIDTH-1:0] p0_rdata;
  logic                  p1_req;
  logic                  p1_we;
  logic [ADDR_WIDTH-1:0] p1_addr;
  logic [DATA_WIDTH-1:0] p1_wdata;
  logic [STRB_WIDTH-1:0] p1_wstrb;
  logic                  p1_gnt;
  logic                  p1_rvalid;
  logic [DATA_WIDTH-1:0] p1_rdata;
  logic                  clr_req;
  logic                  clr_busy;
  logic                  clr_done;
  logic [ADDR_WIDTH-1:0] sram_a;
  logic                  sram_cen;
  logic [STRB_WIDTH-1:0] sram_wen;
  logic [DATA_WIDTH-1:0] sram_d;
  logic [DATA_WIDTH-1:0] sram_q;

  modport master (
    output p0_req, p0_addr,
    output p1_req, p1_we, p1_addr, p1_wdata, p1_wstrb,
    output clr_req, sram_q,
    input  p0_gnt, p0_rvalid, p0_rdata,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  clr_busy, clr_done,
    input  sram_a, sram_cen, sram_wen, sram_d
  );

  modport slave (
    input  p0_req, p0_addr,
    input  p1_req, p1_we, p1_addr, p1_wdata, p1_wstrb,
    input  clr_req, sram_q,
    output p0_gnt, p0_rvalid, p0_rdata,
    output p1_gnt, p1_rvalid, p1_rdata,
    output clr_busy, clr_done,
    output sram_a, sram_cen, sram_wen, sram_d
  );
endinterface

// File: rtl/f_spsram_arb_ctrl.sv
// Two-port SRAM arbiter: p1 priority, p0 anti-starvation.
// Zero-fill engine built only when F_SPSRAM_ARB_CLEAR_EN is defined.
module f_spsram_arb_ctrl #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 128,
  parameter int STRB_WIDTH = 16,
  parameter int STARVE_MAX = 4
) (
  input logic                CLK,
  input logic                RSTN,
  f_spsram_arb_ctrl_if.slave bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  logic                  run;
  logic                  g0;
  logic                  g1;
  logic [SW-1:0]         starve_q, starve_d;
  logic                  p0_rvalid_q, p0_rvalid_d;
  logic                  p1_rvalid_q, p1_rvalid_d;
  logic [ADDR_WIDTH-1:0] sram_a;
  logic                  sram_cen;
  logic [STRB_WIDTH-1:0] sram_wen;
  logic [DATA_WIDTH-1:0] sram_d;

`ifdef F_SPSRAM_ARB_CLEAR_EN
  typedef enum logic {RUN, CLEAR} state_e;
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic                  clr_busy_q, clr_busy_d;
  logic                  clr_done_q, clr_done_d;
  logic                  in_clr;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q    <= RUN;
      clr_addr_q <= '0;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      clr_busy_q <= clr_busy_d;
      clr_done_q <= clr_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    clr_done_d = 1'b0;
    unique case (state_q)
      RUN: begin
        if (bus.clr_req) begin
          state_d    = CLEAR;
          clr_addr_d = '0;
        end
      end
      CLEAR: begin
        clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
        if (&clr_addr_q) begin
          state_d    = RUN;
          clr_done_d = 1'b1;
        end
      end
    endcase
    clr_busy_d = (state_d == CLEAR);
  end

  assign run          = RSTN && (state_q == RUN);
  assign in_clr       = RSTN && (state_q == CLEAR);
  assign bus.clr_busy = clr_busy_q;
  assign bus.clr_done = clr_done_q;
`else
  logic unused_clr_req;

  assign unused_clr_req = bus.clr_req;
  assign run            = RSTN;
  assign bus.clr_busy   = 1'b0;
  assign bus.clr_done   = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      starve_q    <= '0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
    end else begin
      starve_q    <= starve_d;
      p0_rvalid_q <= p0_rvalid_d;
      p1_rvalid_q <= p1_rvalid_d;
    end
  end

  // p0 wins a tie only once p1 has starved it STARVE_MAX times
  always_comb begin
    g1 = run && bus.p1_req
      && !(bus.p0_req && starve_q == SMAX);
    g0 = run && bus.p0_req && !g1;
    starve_d = starve_q;
    if (run) begin
      if (g0 || !bus.p0_req) begin
        starve_d = '0;
      end else if (g1 && starve_q != SMAX) begin
        starve_d = starve_q + SW'(1);
      end
    end
    p0_rvalid_d = g0;
    p1_rvalid_d = g1 && !bus.p1_we;
  end

  always_comb begin
    sram_cen = 1'b1;
    sram_a   = '0;
    sram_wen = '1;
    sram_d   = '0;
    if (g1) begin
      sram_cen = 1'b0;
      sram_a   = bus.p1_addr;
      if (bus.p1_we) begin
        sram_wen = ~bus.p1_wstrb;
        sram_d   = bus.p1_wdata;
      end
    end else if (g0) begin
      sram_cen = 1'b0;
      sram_a   = bus.p0_addr;
    end
`ifdef F_SPSRAM_ARB_CLEAR_EN
    else if (in_clr) begin
      sram_cen = 1'b0;
      sram_a   = clr_addr_q;
      sram_wen = '0;
    end
`endif
  end

  assign bus.p0_gnt    = g0;
  assign bus.p1_gnt    = g1;
  assign bus.p0_rvalid = p0_rvalid_q;
  assign bus.p1_rvalid = p1_rvalid_q;
  assign bus.p0_rdata  = bus.sram_q;
  assign bus.p1_rdata  = bus.sram_q;
  assign bus.sram_a    = sram_a;
  assign bus.sram_cen  = sram_cen;
  assign bus.sram_wen  = sram_wen;
  assign bus.sram_d    = sram_d;
endmodule

// File: tb/tb_f_spsram_arb_ctrl.sv
// Directed bench for f_spsram_arb_ctrl with a behavioural SRAM.
// Zero-fill scenarios follow F_SPSRAM_ARB_CLEAR_EN.
module tb_f_spsram_arb_ctrl;
  logic CLK;
  logic RSTN;
  logic reload;
  logic [127:0] mem [0:32767];
  logic [127:0] q_r;
  int total;
  int bad;

  f_spsram_arb_ctrl_if bus ();

  f_spsram_arb_ctrl dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [127:0] pre(input int i);
    if (i == 32'h1234) return {16{8'h3C}};
    return {4{32'hC0DE_0000 | 32'(i)}};
  endfunction

  assign bus.sram_q = q_r;

  always @(posedge CLK) begin
    if (reload) begin
      for (int i = 0; i < 32768; i++) mem[i] = pre(i);
    end else if (!bus.sram_cen) begin
      q_r <= mem[bus.sram_a];
      for (int b = 0; b < 16; b++)
        if (!bus.sram_wen[b])
          mem[bus.sram_a][b*8 +: 8] = bus.sram_d[b*8 +: 8];
    end
  end

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic rd(input bit port, input logic [14:0] a,
                    input logic [127:0] exp, input string tag);
    tick();
    if (port) begin
      bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = a;
    end else begin
      bus.p0_req = 1'b1; bus.p0_addr = a;
    end
    #1;
    chk({tag, "_gnt"}, port ? bus.p1_gnt : bus.p0_gnt, 1);
    tick();
    bus.p0_req = 1'b0;
    bus.p1_req = 1'b0;
    #1;
    chk({tag, "_rv"}, port ? bus.p1_rvalid : bus.p0_rvalid, 1);
    chk({tag, "_rd"}, port ? bus.p1_rdata : bus.p0_rdata, exp);
  endtask

  initial begin
    bit   hit;
    bit   pg0, pg1;
    bit   eg1;
    int   cnt;
    int   oops;
    total = 0;
    bad = 0;
    RSTN = 1'b0;
    reload = 1'b1;
    q_r = '0;
    bus.p0_req = 1'b1;
    bus.p0_addr = 15'h0;
    bus.p1_req = 1'b1;
    bus.p1_we = 1'b0;
    bus.p1_addr = 15'h0;
    bus.p1_wdata = '0;
    bus.p1_wstrb = '0;
    bus.clr_req = 1'b0;

    // reset: no grants, SRAM idle
    tick(); #1;
    chk("rst_gnt", {bus.p0_gnt, bus.p1_gnt}, 0);
    chk("rst_cen", bus.sram_cen, 1);
    tick();
    reload = 1'b0;
    bus.p0_req = 1'b0;
    bus.p1_req = 1'b0;
    RSTN = 1'b1;
    #1;
    chk("rst_regs", {bus.p0_rvalid, bus.p1_rvalid,
                     bus.clr_busy, bus.clr_done}, 0);

    // p0 read alone
    tick();
    bus.p0_req = 1'b1;
    bus.p0_addr = 15'h0010;
    #1;
    chk("t1_gnt", {bus.p0_gnt, bus.p1_gnt}, 2'b10);
    chk("t1_cen", bus.sram_cen, 0);
    chk("t1_a", bus.sram_a, 15'h0010);
    chk("t1_wen", bus.sram_wen, 16'hFFFF);
    tick();
    bus.p0_req = 1'b0;
    #1;
    chk("t1_rv", {bus.p0_rvalid, bus.p1_rvalid}, 2'b10);
    chk("t1_rd", bus.p0_rdata, pre(32'h10));
    tick(); #1;
    chk("t1_rv_gone", bus.p0_rvalid, 0);

    // p1 partial write, then read back
    tick();
    bus.p1_req = 1'b1;
    bus.p1_we = 1'b1;
    bus.p1_addr = 15'h1234;
    bus.p1_wdata = {16{8'hA5}};
    bus.p1_wstrb = 16'h00FF;
    #1;
    chk("t2_gnt", {bus.p0_gnt, bus.p1_gnt}, 2'b01);
    chk("t2_wen", bus.sram_wen, 16'hFF00);
    chk("t2_d", bus.sram_d, {16{8'hA5}});
    tick();
    bus.p1_req = 1'b0;
    #1;
    chk("t2_no_rv", bus.p1_rvalid, 0);
    rd(1'b1, 15'h1234, {{8{8'h3C}}, {8{8'hA5}}}, "t2_rb");

    // zero strobe write: granted, nothing changes
    tick();
    bus.p1_req = 1'b1;
    bus.p1_we = 1'b1;
    bus.p1_addr = 15'h1234;
    bus.p1_wdata = '0;
    bus.p1_wstrb = 16'h0000;
    #1;
    chk("ws0_gnt", bus.p1_gnt, 1);
    chk("ws0_cen", bus.sram_cen, 0);
    chk("ws0_wen", bus.sram_wen, 16'hFFFF);
    tick();
    bus.p1_req = 1'b0;
    bus.p1_we = 1'b0;
    rd(1'b1, 15'h1234, {{8{8'h3C}}, {8{8'hA5}}}, "ws0_rb");

    // contention: p1 x4 then p0, repeating
    tick();
    bus.p0_req = 1'b1;
    bus.p0_addr = 15'h0020;
    bus.p1_req = 1'b1;
    bus.p1_we = 1'b0;
    bus.p1_addr = 15'h0030;
    pg0 = 1'b0;
    pg1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i != 0) tick();
      #1;
      eg1 = (i % 5) != 4;
      chk("t3_gnt", {bus.p0_gnt, bus.p1_gnt}, {!eg1, eg1});
      if (i != 0)
        chk("t3_rv", {bus.p0_rvalid, bus.p1_rvalid}, {pg0, pg1});
      pg0 = !eg1;
      pg1 = eg1;
    end
    tick();
    bus.p0_req = 1'b0;
    bus.p1_req = 1'b0;
    #1;
    chk("t3_rv_last", {bus.p0_rvalid, bus.p1_rvalid}, 2'b10);

`ifdef F_SPSRAM_ARB_CLEAR_EN
    // full zero-fill with a read granted in the clr_req cycle
    tick();
    bus.clr_req = 1'b1;
    bus.p0_req = 1'b1;
    bus.p0_addr = 15'h0005;
    #1;
    chk("t4_gnt0", bus.p0_gnt, 1);
    tick();
    bus.clr_req = 1'b0;
    bus.p0_addr = 15'h7FFF;
    #1;
    chk("t4_rv", bus.p0_rvalid, 1);
    chk("t4_rd", bus.p0_rdata, pre(5));
    cnt = 0;
    oops = 0;
    while (bus.clr_busy && cnt < 40000) begin
      if (bus.p0_gnt || bus.p1_gnt) oops++;
      if (bus.sram_cen !== 1'b0 || bus.sram_wen !== 16'h0
          || bus.sram_d !== '0 || bus.sram_a !== 15'(cnt))
        oops++;
      cnt++;
      tick(); #1;
    end
    chk("t4_cycles", cnt, 32768);
    chk("t4_bad_cyc", oops, 0);
    chk("t4_done", {bus.clr_done, bus.clr_busy}, 2'b10);
    chk("t4_gnt_after", bus.p0_gnt, 1);
    tick();
    bus.p0_req = 1'b0;
    #1;
    chk("t4_done_pulse", bus.clr_done, 0);
    chk("t4_rv_7fff", bus.p0_rvalid, 1);
    chk("t4_rd_7fff", bus.p0_rdata, 0);

    // reset in the middle of a zero-fill
    tick();
    reload = 1'b1;
    tick();
    reload = 1'b0;
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    hit = 1'b0;
    for (int j = 0; j < 1000 && !hit; j++) begin
      #1;
      if (bus.clr_busy && bus.sram_a == 15'h0100) begin
        RSTN = 1'b0;
        hit = 1'b1;
      end else begin
        tick();
      end
    end
    chk("t5_reached", hit, 1);
    #1;
    chk("t5_cen", bus.sram_cen, 1);
    tick(); #1;
    chk("t5_after_rst", {bus.clr_busy, bus.clr_done}, 0);
    RSTN = 1'b1;
    tick(); #1;
    chk("t5_no_done", {bus.clr_busy, bus.clr_done}, 0);
    rd(1'b0, 15'h00FF, 0, "t5_ff");
    rd(1'b0, 15'h0100, pre(32'h100), "t5_100");
`else
    // clr_req ignored while p0 streams
    tick();
    bus.p0_req = 1'b1;
    bus.p0_addr = 15'h0040;
    for (int i = 0; i < 6; i++) begin
      if (i != 0) tick();
      bus.clr_req = (i == 2);
      #1;
      chk("t6_run", {bus.p0_gnt, bus.clr_busy, bus.clr_done}, 3'b100);
    end
    tick();
    bus.clr_req = 1'b0;
    bus.p0_req = 1'b0;
    #1;
    chk("t6_idle", {bus.clr_busy, bus.clr_done}, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
